// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub
// Pipelined carry-lookahead adder/subtractor for the execute path.
// The operand word is cut into STAGES slices of CHUNK = WIDTH/STAGES bits.
// Stage k adds slice k with a CHUNK-bit lookahead adder and registers its
// carry for stage k+1. Unconsumed operand slices and finished sum slices
// travel with the transaction.
//
// Optional build macro: CLA_PIPE_SAT_EN adds the 'sat' input. When sat is set
// and the result overflows, s is clamped to the signed limit.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake
//   a, b, ci, sub         operands; sub=0: a+b+ci, sub=1: a-b-ci
//   sat                   (CLA_PIPE_SAT_EN only) saturate on signed overflow
//   out_valid / out_ready result handshake
//   s, co, ovf, zero      result and flags (meaningful while out_valid=1)
//
// Handshake: a beat moves when valid && ready on that side. The whole pipe
// advances together (adv). in_ready = adv = !out_valid || out_ready. Any
// stall therefore freezes every stage, and in_valid is ignored meanwhile.
module cla_pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
`ifdef CLA_PIPE_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    if ((WIDTH % STAGES) != 0) begin : g_bad_params
        $error("cla_pipe_addsub: WIDTH must be divisible by STAGES");
    end

    // CHUNK-bit lookahead adder. Each carry is formed directly from the
    // generate/propagate terms of the bits below it, so no carry depends on
    // the carry computed for its neighbour.
    function automatic logic [CHUNK:0] cla_slice(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             cin);
        logic [CHUNK-1:0] g;
        logic [CHUNK-1:0] p;
        logic [CHUNK:0]   c;
        logic             term;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            // Carry-in propagated through bits 0..i.
            term = cin;
            for (int j = 0; j <= i; j++) term = term & p[j];
            c[i+1] = term;
            // Generate at bit j, propagated through bits j+1..i.
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term = term & p[m];
                c[i+1] = c[i+1] | term;
            end
        end
        return {c[CHUNK], p ^ c[CHUNK-1:0]};
    endfunction

    // Stage k registers (output side of stage k).
    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  acc_q [STAGES];  // sum slices 0..k, operand a above
    logic [WIDTH-1:0]  b_q   [STAGES];  // conditioned operand b
    logic              c_q   [STAGES];  // carry out of slice k
`ifdef CLA_PIPE_SAT_EN
    logic              sat_q [STAGES];
`endif
    logic              ovf_q;
    logic              zero_q;

    // Next-state values for each stage.
    logic [STAGES-1:0] nxt_v;
    logic [WIDTH-1:0]  nxt_acc [STAGES];
    logic [WIDTH-1:0]  nxt_b   [STAGES];
    logic              nxt_c   [STAGES];
`ifdef CLA_PIPE_SAT_EN
    logic              nxt_sat [STAGES];
    logic              sat_in;
`endif
    logic              ovf_d;
    logic              zero_d;
    logic [WIDTH-1:0]  acc_in;
    logic [WIDTH-1:0]  b_in;
    logic              c_in;
    logic [CHUNK:0]    slice_res;
    int                prev_k;

    logic adv;

    assign adv       = !v_q[LAST] || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[LAST];
    assign s         = acc_q[LAST];
    assign co        = c_q[LAST];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    always_comb begin
        nxt_v     = '0;
        ovf_d     = 1'b0;
        zero_d    = 1'b0;
        acc_in    = '0;
        b_in      = '0;
        c_in      = 1'b0;
        slice_res = '0;
        prev_k    = 0;
`ifdef CLA_PIPE_SAT_EN
        sat_in    = 1'b0;
`endif
        for (int k = 0; k < STAGES; k++) begin
            prev_k = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                // Subtraction is a + ~b + ~ci = a - b - ci.
                acc_in   = a;
                b_in     = sub ? ~b : b;
                c_in     = sub ? ~ci : ci;
                nxt_v[k] = in_valid;
`ifdef CLA_PIPE_SAT_EN
                sat_in   = sat;
`endif
            end else begin
                acc_in   = acc_q[prev_k];
                b_in     = b_q[prev_k];
                c_in     = c_q[prev_k];
                nxt_v[k] = v_q[prev_k];
`ifdef CLA_PIPE_SAT_EN
                sat_in   = sat_q[prev_k];
`endif
            end
            slice_res  = cla_slice(acc_in[k*CHUNK +: CHUNK], b_in[k*CHUNK +: CHUNK], c_in);
            nxt_acc[k] = acc_in;
            nxt_acc[k][k*CHUNK +: CHUNK] = slice_res[CHUNK-1:0];
            nxt_b[k]   = b_in;
            nxt_c[k]   = slice_res[CHUNK];
`ifdef CLA_PIPE_SAT_EN
            nxt_sat[k] = sat_in;
`endif
            if (k == LAST) begin
                // acc_in still holds a in its top slice; slice_res MSB is s MSB.
                ovf_d = (acc_in[WIDTH-1] == b_in[WIDTH-1]) &&
                        (slice_res[CHUNK-1] != acc_in[WIDTH-1]);
`ifdef CLA_PIPE_SAT_EN
                if (sat_in && ovf_d) begin
                    nxt_acc[k] = acc_in[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                 : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
                zero_d = (nxt_acc[k] == '0);
            end
        end
    end

    // Data registers only load when a valid beat enters them, so the outputs
    // and flags hold their last value across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                acc_q[k] <= '0;
                b_q[k]   <= '0;
                c_q[k]   <= 1'b0;
`ifdef CLA_PIPE_SAT_EN
                sat_q[k] <= 1'b0;
`endif
            end
        end else if (adv) begin
            v_q <= nxt_v;
            for (int k = 0; k < STAGES; k++) begin
                if (nxt_v[k]) begin
                    acc_q[k] <= nxt_acc[k];
                    b_q[k]   <= nxt_b[k];
                    c_q[k]   <= nxt_c[k];
`ifdef CLA_PIPE_SAT_EN
                    sat_q[k] <= nxt_sat[k];
`endif
                end
            end
            if (nxt_v[LAST]) begin
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
module tb_cla_pipe_addsub;

    localparam int W = 32;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
    logic         zero;
`ifdef CLA_PIPE_SAT_EN
    logic         sat;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [W-1:0] exp_q[$];

    // Sweep instances: WIDTH=8, STAGES = 1, 2, 8, sharing one input bus.
    logic       sw_valid;
    logic [7:0] sw_a;
    logic [7:0] sw_b;
    logic       sw_ci;
    logic       sw_sub;
    logic [2:0] sw_rdy;
    logic [2:0] sw_ov;
    logic [7:0] sw_s [3];
    logic [2:0] sw_co;
    logic [2:0] sw_ovf;
    logic [2:0] sw_z;
    int         sw_lat [3] = '{1, 2, 8};

    always #5 clk = ~clk;

    cla_pipe_addsub #(.WIDTH(W), .STAGES(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub),
`ifdef CLA_PIPE_SAT_EN
        .sat(sat),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .co(co), .ovf(ovf), .zero(zero)
    );

    cla_pipe_addsub #(.WIDTH(8), .STAGES(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_rdy[0]),
        .a(sw_a), .b(sw_b), .ci(sw_ci), .sub(sw_sub),
`ifdef CLA_PIPE_SAT_EN
        .sat(1'b0),
`endif
        .out_valid(sw_ov[0]), .out_ready(1'b1),
        .s(sw_s[0]), .co(sw_co[0]), .ovf(sw_ovf[0]), .zero(sw_z[0])
    );

    cla_pipe_addsub #(.WIDTH(8), .STAGES(2)) dut_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_rdy[1]),
        .a(sw_a), .b(sw_b), .ci(sw_ci), .sub(sw_sub),
`ifdef CLA_PIPE_SAT_EN
        .sat(1'b0),
`endif
        .out_valid(sw_ov[1]), .out_ready(1'b1),
        .s(sw_s[1]), .co(sw_co[1]), .ovf(sw_ovf[1]), .zero(sw_z[1])
    );

    cla_pipe_addsub #(.WIDTH(8), .STAGES(8)) dut_s8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_rdy[2]),
        .a(sw_a), .b(sw_b), .ci(sw_ci), .sub(sw_sub),
`ifdef CLA_PIPE_SAT_EN
        .sat(1'b0),
`endif
        .out_valid(sw_ov[2]), .out_ready(1'b1),
        .s(sw_s[2]), .co(sw_co[2]), .ovf(sw_ovf[2]), .zero(sw_z[2])
    );

    // Driver: present one transaction, then wait (bounded) for its result.
    task automatic send_and_wait(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                 input logic tci, input logic tsub,
                                 output int lat, output logic [W-1:0] rs,
                                 output logic rco, output logic rovf, output logic rzero);
        @(posedge clk); #1;
        a = ta; b = tb_v; ci = tci; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rs = s; rco = co; rovf = ovf; rzero = zero;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_ci = 1'b0; sw_sub = 1'b0;
`ifdef CLA_PIPE_SAT_EN
        sat = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (s !== '0) $display("FAIL reset_s: got %h want 0", s); else pass_cnt++;
        total_cnt++; if ({co, ovf, zero} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {co, ovf, zero}); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (sw_ov !== 3'b000) $display("FAIL reset_sweep_valid: got %b want 000", sw_ov); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_add_ci();
        int lat; logic [W-1:0] rs; logic rco, rovf, rz;
        send_and_wait(32'd98, 32'd1, 1'b1, 1'b0, lat, rs, rco, rovf, rz);
        total_cnt++; if (lat !== 4) $display("FAIL add_ci_latency: got %0d want 4", lat); else pass_cnt++;
        total_cnt++; if (rs !== 32'd100) $display("FAIL add_ci_s: got %0d want 100", rs); else pass_cnt++;
        total_cnt++; if ({rco, rovf, rz} !== 3'b000) $display("FAIL add_ci_flags: got %b want 000", {rco, rovf, rz}); else pass_cnt++;
        // Output consumed with out_ready=1 and no new input: valid must drop.
        @(posedge clk); #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL add_ci_drain: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (s !== 32'd100) $display("FAIL add_ci_hold: got %0d want 100", s); else pass_cnt++;
    endtask

    task automatic test_carry_chain();
        int lat; logic [W-1:0] rs; logic rco, rovf, rz;
        send_and_wait(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, rs, rco, rovf, rz);
        total_cnt++; if (lat !== 4) $display("FAIL chain_latency: got %0d want 4", lat); else pass_cnt++;
        total_cnt++; if (rs !== 32'h0) $display("FAIL chain_s: got %h want 00000000", rs); else pass_cnt++;
        total_cnt++; if ({rco, rovf, rz} !== 3'b101) $display("FAIL chain_flags co/ovf/zero: got %b want 101", {rco, rovf, rz}); else pass_cnt++;
    endtask

    task automatic test_subtract();
        int lat; logic [W-1:0] rs; logic rco, rovf, rz;
        send_and_wait(32'd5, 32'd7, 1'b0, 1'b1, lat, rs, rco, rovf, rz);
        total_cnt++; if (rs !== 32'hFFFF_FFFE) $display("FAIL sub_borrow_s: got %h want fffffffe", rs); else pass_cnt++;
        total_cnt++; if ({rco, rovf, rz} !== 3'b000) $display("FAIL sub_borrow_flags: got %b want 000", {rco, rovf, rz}); else pass_cnt++;
        send_and_wait(32'd10, 32'd3, 1'b1, 1'b1, lat, rs, rco, rovf, rz);
        total_cnt++; if (rs !== 32'd6) $display("FAIL sub_bin_s: got %0d want 6", rs); else pass_cnt++;
        total_cnt++; if ({rco, rovf, rz} !== 3'b100) $display("FAIL sub_bin_flags: got %b want 100", {rco, rovf, rz}); else pass_cnt++;
        send_and_wait(32'd9, 32'd9, 1'b0, 1'b1, lat, rs, rco, rovf, rz);
        total_cnt++; if ({rs, rco, rovf, rz} !== {32'd0, 3'b101}) $display("FAIL sub_equal: got s=%h flags=%b want 0/101", rs, {rco, rovf, rz}); else pass_cnt++;
    endtask

    task automatic test_overflow();
        int lat; logic [W-1:0] rs; logic rco, rovf, rz;
        send_and_wait(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, lat, rs, rco, rovf, rz);
        total_cnt++; if (rs !== 32'h8000_0000) $display("FAIL ovf_add_s: got %h want 80000000", rs); else pass_cnt++;
        total_cnt++; if ({rco, rovf, rz} !== 3'b010) $display("FAIL ovf_add_flags: got %b want 010", {rco, rovf, rz}); else pass_cnt++;
        send_and_wait(32'h8000_0000, 32'd1, 1'b0, 1'b1, lat, rs, rco, rovf, rz);
        total_cnt++; if (rs !== 32'h7FFF_FFFF) $display("FAIL ovf_sub_s: got %h want 7fffffff", rs); else pass_cnt++;
        total_cnt++; if ({rco, rovf, rz} !== 3'b110) $display("FAIL ovf_sub_flags: got %b want 110", {rco, rovf, rz}); else pass_cnt++;
`ifdef CLA_PIPE_SAT_EN
        sat = 1'b1;
        send_and_wait(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, lat, rs, rco, rovf, rz);
        total_cnt++; if (lat !== 4) $display("FAIL sat_latency: got %0d want 4", lat); else pass_cnt++;
        total_cnt++; if (rs !== 32'h7FFF_FFFF) $display("FAIL sat_pos_s: got %h want 7fffffff", rs); else pass_cnt++;
        total_cnt++; if ({rco, rovf, rz} !== 3'b010) $display("FAIL sat_pos_flags: got %b want 010", {rco, rovf, rz}); else pass_cnt++;
        send_and_wait(32'h8000_0000, 32'd1, 1'b0, 1'b1, lat, rs, rco, rovf, rz);
        total_cnt++; if (rs !== 32'h8000_0000) $display("FAIL sat_neg_s: got %h want 80000000", rs); else pass_cnt++;
        total_cnt++; if ({rco, rovf, rz} !== 3'b110) $display("FAIL sat_neg_flags: got %b want 110", {rco, rovf, rz}); else pass_cnt++;
        send_and_wait(32'd20, 32'd22, 1'b0, 1'b0, lat, rs, rco, rovf, rz);
        total_cnt++; if (rs !== 32'd42) $display("FAIL sat_no_ovf_s: got %0d want 42", rs); else pass_cnt++;
        sat = 1'b0;
`endif
    endtask

    // Stream 1+1..8+8 back to back; out_ready low in cycles 6..8.
    task automatic test_back_pressure();
        int item;
        logic [W-1:0] e;
        logic stall;
        item = 1;
        exp_q.delete();
        for (int i = 1; i <= 8; i++) exp_q.push_back(W'(2 * i));
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            stall     = (c >= 6 && c <= 8);
            in_valid  = (item <= 8);
            a         = W'(item);
            b         = W'(item);
            ci        = 1'b0;
            sub       = 1'b0;
            out_ready = !stall;
            #1;
            total_cnt++; if (in_ready !== !stall) $display("FAIL bp_in_ready cycle %0d: got %b want %b", c, in_ready, !stall); else pass_cnt++;
            if (stall) begin
                total_cnt++; if (out_valid !== 1'b1 || s !== 32'd4) $display("FAIL bp_stall_hold cycle %0d: got valid=%b s=%0d want valid=1 s=4", c, out_valid, s); else pass_cnt++;
            end
            if (out_valid && out_ready) begin
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL bp_extra_output: got s=%0d want none", s);
                else begin
                    e = exp_q.pop_front();
                    if (s !== e) $display("FAIL bp_order: got %0d want %0d", s, e); else pass_cnt++;
                end
            end
            if (in_valid && in_ready) item++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total_cnt++; if (exp_q.size() != 0) $display("FAIL bp_missing: got %0d outstanding want 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_reset_mid_stream();
        int lat; logic [W-1:0] rs; logic rco, rovf, rz;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            in_valid = (c <= 4); a = W'(c); b = W'(c); ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
        end
        #1;
        total_cnt++; if (out_valid !== 1'b1 || s !== 32'd2) $display("FAIL rst_pre: got valid=%b s=%0d want 1/2", out_valid, s); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_async_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (s !== '0) $display("FAIL rst_async_s: got %h want 0", s); else pass_cnt++;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_stale cycle %0d: got %b want 0", k, out_valid); else pass_cnt++;
        end
        send_and_wait(32'd3, 32'd4, 1'b0, 1'b0, lat, rs, rco, rovf, rz);
        total_cnt++; if (lat !== 4) $display("FAIL rst_new_latency: got %0d want 4", lat); else pass_cnt++;
        total_cnt++; if (rs !== 32'd7) $display("FAIL rst_new_s: got %0d want 7", rs); else pass_cnt++;
    endtask

    task automatic test_param_sweep();
        logic [7:0] va [12];
        logic [7:0] vb [12];
        logic       vci [12];
        logic       vsub [12];
        int t, sa, sb, sr;
        logic [7:0] es;
        logic eco, eovf, ez;
        va[0] = 8'hFF; vb[0] = 8'h01; vci[0] = 1'b0; vsub[0] = 1'b0;
        va[1] = 8'h7F; vb[1] = 8'h01; vci[1] = 1'b0; vsub[1] = 1'b0;
        va[2] = 8'h80; vb[2] = 8'h01; vci[2] = 1'b0; vsub[2] = 1'b1;
        va[3] = 8'h05; vb[3] = 8'h07; vci[3] = 1'b0; vsub[3] = 1'b1;
        va[4] = 8'h10; vb[4] = 8'h10; vci[4] = 1'b1; vsub[4] = 1'b1;
        va[5] = 8'hC8; vb[5] = 8'h64; vci[5] = 1'b1; vsub[5] = 1'b0;
        for (int v = 6; v < 12; v++) begin
            va[v] = 8'($urandom_range(0, 255)); vb[v] = 8'($urandom_range(0, 255));
            vci[v] = 1'($urandom_range(0, 1)); vsub[v] = 1'($urandom_range(0, 1));
        end
        for (int v = 0; v < 12; v++) begin
            // Arithmetic reference: unsigned and signed results in plain ints.
            sa = (va[v] >= 8'd128) ? int'(va[v]) - 256 : int'(va[v]);
            sb = (vb[v] >= 8'd128) ? int'(vb[v]) - 256 : int'(vb[v]);
            if (vsub[v]) begin
                t   = int'(va[v]) - int'(vb[v]) - int'(vci[v]);
                eco = (t >= 0);
                sr  = sa - sb - int'(vci[v]);
            end else begin
                t   = int'(va[v]) + int'(vb[v]) + int'(vci[v]);
                eco = (t > 255);
                sr  = sa + sb + int'(vci[v]);
            end
            es   = t[7:0];
            eovf = (sr > 127) || (sr < -128);
            ez   = (es == 8'd0);
            @(posedge clk); #1;
            sw_valid = 1'b1; sw_a = va[v]; sw_b = vb[v]; sw_ci = vci[v]; sw_sub = vsub[v];
            for (int n = 1; n <= 10; n++) begin
                @(posedge clk); #1;
                sw_valid = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    total_cnt++; if (sw_ov[i] !== (n == sw_lat[i])) $display("FAIL sweep_valid st=%0d vec=%0d cyc=%0d: got %b want %b", sw_lat[i], v, n, sw_ov[i], (n == sw_lat[i])); else pass_cnt++;
                    if (n == sw_lat[i]) begin
                        total_cnt++;
                        if ({sw_s[i], sw_co[i], sw_ovf[i], sw_z[i]} !== {es, eco, eovf, ez})
                            $display("FAIL sweep_result st=%0d vec=%0d: got s=%h co=%b ovf=%b z=%b want s=%h co=%b ovf=%b z=%b",
                                     sw_lat[i], v, sw_s[i], sw_co[i], sw_ovf[i], sw_z[i], es, eco, eovf, ez);
                        else pass_cnt++;
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_ci();
        test_carry_chain();
        test_subtract();
        test_overflow();
        test_back_pressure();
        test_reset_mid_stream();
        test_param_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
